fetch_queue: RTL

Parametrised decoupling buffer between the instruction cache output and the predecoder. It holds up to DEPTH fetch bundles. Each bundle carries FETCH_WIDTH instruction words plus its PC, fetch exception and BTB metadata. Flush, occupancy/almost-full reporting and per-slot valid masks are included, so icache stalls and rename backpressure are absorbed instead of propagating through a single busy chain.

---
 rtl/fetch_queue_pkg.sv | 38 +++
 rtl/fq_slot_mask.sv | 33 +++
 rtl/fetch_queue.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_pkg
// Description : Shared frontend types for the fetch queue: stored entry
//               layout, BTB branch-type encodings, fetch exception codes.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

    // The entry is sized for the widest supported bundle; narrower
    // configurations leave the upper instruction and mask bits at zero.
    localparam int FQ_MAX_FW = 4;

    localparam logic [1:0] c_BTYPE_NONE = 2'd0;
    localparam logic [1:0] c_BTYPE_COND = 2'd1;
    localparam logic [1:0] c_BTYPE_JUMP = 2'd2;
    localparam logic [1:0] c_BTYPE_RET  = 2'd3;

    localparam logic [3:0] c_EXC_IMISALIGN = 4'd0;
    localparam logic [3:0] c_EXC_IACCESS   = 4'd1;
    localparam logic [3:0] c_EXC_IPAGE     = 4'd12;

    typedef struct packed {
        logic [32*FQ_MAX_FW-1:0] instr;
        logic [31:0]             pc;
        logic                    excp_vld;
        logic [3:0]              excp_code;
        logic                    btb_vld;
        logic [1:0]              btype;
        logic [1:0]              bm_pred;
        logic [31:0]             target;
        logic                    idx;
        logic                    way;
        logic [FQ_MAX_FW-1:0]    slot_mask;
    } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/fq_slot_mask.sv
`default_nettype none
// ============================================================================
// Module      : fq_slot_mask
// Description : Maps the fetch PC word offset to the valid-slot mask of a
//               bundle; slots before the entry point are invalid.
// Revision    : 1.0 - initial release
// ============================================================================
module fq_slot_mask #(
    parameter int FETCH_WIDTH = 2
) (
    input  logic [31:0]            pc,
    output logic [FETCH_WIDTH-1:0] slot_mask
);

    if (FETCH_WIDTH == 1) begin : g_single
        logic w_unused_pc;
        assign w_unused_pc = ^pc;
        assign slot_mask   = 1'b1;
    end else begin : g_multi
        localparam int c_OFF_W = $clog2(FETCH_WIDTH);
        logic [c_OFF_W-1:0] w_off;
        logic               w_unused_pc;

        assign w_off       = pc[c_OFF_W+1:2];
        assign w_unused_pc = ^{pc[31:c_OFF_W+2], pc[1:0]};

        for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_bit
            assign slot_mask[i] = (c_OFF_W'(i) >= w_off);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular decoupling buffer between icache and predecoder,
//               with flush, registered occupancy/almost-full and slot masks.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FETCH_WIDTH  = 2,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                          cpu_clock_i,
    input  logic                          cpu_resetn_i,
    input  logic                          flush_i,

    input  logic                          enq_valid_i,
    output logic                          enq_busy_o,
    input  logic [32*FETCH_WIDTH-1:0]     enq_instr_i,
    input  logic [31:0]                   enq_pc_i,
    input  logic                          enq_excp_vld_i,
    input  logic [3:0]                    enq_excp_code_i,
    input  logic                          enq_btb_vld_i,
    input  logic [1:0]                    enq_btb_btype_i,
    input  logic [1:0]                    enq_btb_bm_pred_i,
    input  logic [31:0]                   enq_btb_target_i,
    input  logic                          enq_btb_idx_i,
    input  logic                          enq_btb_way_i,

    output logic                          deq_valid_o,
    input  logic                          deq_busy_i,
    output logic [32*FETCH_WIDTH-1:0]     deq_instr_o,
    output logic [31:0]                   deq_pc_o,
    output logic                          deq_excp_vld_o,
    output logic [3:0]                    deq_excp_code_o,
    output logic                          deq_btb_vld_o,
    output logic [1:0]                    deq_btb_btype_o,
    output logic [1:0]                    deq_btb_bm_pred_o,
    output logic [31:0]                   deq_btb_target_o,
    output logic                          deq_btb_idx_o,
    output logic                          deq_btb_way_o,
    output logic [FETCH_WIDTH-1:0]        deq_slot_mask_o,

    output logic [$clog2(DEPTH+1)-1:0]    occupancy_o,
    output logic                          almost_full_o
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_PTR_W = c_IDX_W + 1;
    localparam int c_OCC_W = $clog2(DEPTH + 1);

    logic [c_PTR_W-1:0]     r_wptr;
    logic [c_PTR_W-1:0]     r_rptr;
    logic [c_OCC_W-1:0]     r_occ;
    logic [c_OCC_W-1:0]     w_occ_nxt;
    logic                   r_afull;
    fq_entry_t              r_mem [DEPTH];
    fq_entry_t              w_enq_entry;
    fq_entry_t              w_head;
    logic [FETCH_WIDTH-1:0] w_enq_mask;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;

    fq_slot_mask #(
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_slot_mask (
        .pc        (enq_pc_i),
        .slot_mask (w_enq_mask)
    );

    assign w_full  = (r_wptr[c_IDX_W-1:0] == r_rptr[c_IDX_W-1:0]) &&
                     (r_wptr[c_IDX_W] != r_rptr[c_IDX_W]);
    assign w_empty = (r_wptr == r_rptr);
    // Full is judged on registered state, so a same-cycle pop never frees a slot.
    assign w_push  = enq_valid_i && !w_full;
    assign w_pop   = !w_empty && !deq_busy_i;

    always_comb begin
        w_enq_entry                                = '0;
        w_enq_entry.instr[32*FETCH_WIDTH-1:0]      = enq_instr_i;
        w_enq_entry.pc                             = enq_pc_i;
        w_enq_entry.excp_vld                       = enq_excp_vld_i;
        w_enq_entry.excp_code                      = enq_excp_code_i;
        w_enq_entry.btb_vld                        = enq_btb_vld_i;
        w_enq_entry.btype                          = enq_btb_btype_i;
        w_enq_entry.bm_pred                        = enq_btb_bm_pred_i;
        w_enq_entry.target                         = enq_btb_target_i;
        w_enq_entry.idx                            = enq_btb_idx_i;
        w_enq_entry.way                            = enq_btb_way_i;
        w_enq_entry.slot_mask[FETCH_WIDTH-1:0]     = w_enq_mask;
    end

    always_comb begin
        w_occ_nxt = r_occ;
        if (flush_i) begin
            w_occ_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_occ_nxt = r_occ + c_OCC_W'(1);
        end else if (!w_push && w_pop) begin
            w_occ_nxt = r_occ - c_OCC_W'(1);
        end
    end

    always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
        if (!cpu_resetn_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_afull <= 1'b0;
        end else begin
            if (flush_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
                if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
            end
            r_occ   <= w_occ_nxt;
            r_afull <= (w_occ_nxt >= c_OCC_W'(AFULL_THRESH));
        end
    end

    // Payload storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge cpu_clock_i) begin
        if (w_push && !flush_i) begin
            r_mem[r_wptr[c_IDX_W-1:0]] <= w_enq_entry;
        end
    end

    assign w_head = r_mem[r_rptr[c_IDX_W-1:0]];

    if (FETCH_WIDTH < FQ_MAX_FW) begin : g_unused_hi
        logic w_unused_hi;
        assign w_unused_hi = ^{w_head.instr[32*FQ_MAX_FW-1:32*FETCH_WIDTH],
                               w_head.slot_mask[FQ_MAX_FW-1:FETCH_WIDTH]};
    end

    assign enq_busy_o        = w_full;
    assign deq_valid_o       = !w_empty;
    assign deq_instr_o       = w_head.instr[32*FETCH_WIDTH-1:0];
    assign deq_pc_o          = w_head.pc;
    assign deq_excp_vld_o    = w_head.excp_vld;
    assign deq_excp_code_o   = w_head.excp_code;
    assign deq_btb_vld_o     = w_head.btb_vld;
    assign deq_btb_btype_o   = w_head.btype;
    assign deq_btb_bm_pred_o = w_head.bm_pred;
    assign deq_btb_target_o  = w_head.target;
    assign deq_btb_idx_o     = w_head.idx;
    assign deq_btb_way_o     = w_head.way;
    assign deq_slot_mask_o   = w_head.slot_mask[FETCH_WIDTH-1:0];
    assign occupancy_o       = r_occ;
    assign almost_full_o     = r_afull;

endmodule
`default_nettype wire
